// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types and default sizes for the dual-port RAM initiator
package dpram_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int RAM_WIDTH_DEF = 8;
    localparam int ADDR_SIZE_DEF = 8;
    localparam int RSP_DEPTH     = 2;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// rtl/dpram_rsp_fifo.sv - 2-entry synchronous read-response FIFO
module dpram_rsp_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // Storage and pointers; a push into the slot being popped is safe because the head is read before the edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

endmodule

// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - valid/ready initiator and fill engine for the dual-port RAM (optional ACCESS_CNT_EN counters)
module dpram_port_master
    import dpram_pkg::*;
#(
    parameter int RAM_WIDTH = RAM_WIDTH_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int RAM_DEPTH = 2 ** ADDR_SIZE,
    parameter int RSP_DEPTH = dpram_pkg::RSP_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [ADDR_SIZE-1:0] wr_req_addr,
    input  logic [RAM_WIDTH-1:0] wr_req_data,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [ADDR_SIZE-1:0] rd_req_addr,
    output logic                 rd_rsp_valid,
    input  logic                 rd_rsp_ready,
    output logic [RAM_WIDTH-1:0] rd_rsp_data,
    input  logic                 fill_start,
    input  logic [RAM_WIDTH-1:0] fill_value,
    output logic                 fill_busy,
    output logic                 fill_done,
`ifdef ACCESS_CNT_EN
    output logic [15:0]          wr_count,
    output logic [15:0]          rd_count,
`endif
    output logic                 ram_wr_en,
    output logic [ADDR_SIZE-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    // One extra bit so the terminal count RAM_DEPTH is distinct from address 0
    localparam int CNT_W = ADDR_SIZE + 1;

    state_e               state_q;
    logic [CNT_W-1:0]     fill_cnt_q;
    logic [RAM_WIDTH-1:0] fill_val_q;
    logic                 fill_done_q;
    logic                 ram_wr_en_q;
    logic [ADDR_SIZE-1:0] ram_wr_addr_q;
    logic [RAM_WIDTH-1:0] ram_data_in_q;
    logic                 ram_rd_en_q;
    logic [ADDR_SIZE-1:0] ram_rd_addr_q;

    logic                 accept_ok;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 rsp_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2:0]           credits_used;

    // Host traffic is only taken while idle and not on the cycle a fill is launched
    assign accept_ok    = !rst && (state_q == IDLE) && !fill_start;
    assign rsp_pop      = !fifo_empty && rd_rsp_ready;
    // Buffered plus in-flight responses, less the one leaving this cycle
    assign credits_used = (fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1))
                        + {2'b00, ram_rd_en_q} - {2'b00, rsp_pop};
    assign wr_req_ready = accept_ok;
    assign rd_req_ready = accept_ok && (credits_used < 3'(RSP_DEPTH));
    assign wr_fire      = wr_req_valid && wr_req_ready;
    assign rd_fire      = rd_req_valid && rd_req_ready;

    assign fill_busy    = (state_q == FILL);
    assign fill_done    = fill_done_q;
    assign ram_wr_en    = ram_wr_en_q;
    assign ram_wr_addr  = ram_wr_addr_q;
    assign ram_data_in  = ram_data_in_q;
    assign ram_rd_en    = ram_rd_en_q;
    assign ram_rd_addr  = ram_rd_addr_q;
    assign rd_rsp_valid = !fifo_empty;

    // Fill sequencing and write-strobe generation; host writes pass through when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fill_cnt_q    <= '0;
            fill_val_q    <= '0;
            fill_done_q   <= 1'b0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_data_in_q <= '0;
        end else begin
            fill_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        state_q       <= FILL;
                        fill_val_q    <= fill_value;
                        fill_cnt_q    <= CNT_W'(1);
                        ram_wr_en_q   <= 1'b1;
                        ram_wr_addr_q <= '0;
                        ram_data_in_q <= fill_value;
                    end else begin
                        ram_wr_en_q <= wr_fire;
                        if (wr_fire) begin
                            ram_wr_addr_q <= wr_req_addr;
                            ram_data_in_q <= wr_req_data;
                        end
                    end
                end
                FILL: begin
                    if (fill_cnt_q == CNT_W'(RAM_DEPTH)) begin
                        state_q     <= IDLE;
                        fill_cnt_q  <= '0;
                        ram_wr_en_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end else begin
                        ram_wr_en_q   <= 1'b1;
                        ram_wr_addr_q <= fill_cnt_q[ADDR_SIZE-1:0];
                        ram_data_in_q <= fill_val_q;
                        fill_cnt_q    <= fill_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read strobe lasts exactly one cycle per accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_en_q   <= 1'b0;
            ram_rd_addr_q <= '0;
        end else begin
            ram_rd_en_q <= rd_fire;
            if (rd_fire) begin
                ram_rd_addr_q <= rd_req_addr;
            end
        end
    end

    dpram_rsp_fifo #(
        .WIDTH(RAM_WIDTH)
    ) u_rsp_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (ram_rd_en_q),
        .push_data_i(ram_data_out),
        .pop_i      (rsp_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .data_o     (rd_rsp_data)
    );

`ifdef ACCESS_CNT_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

    // Saturating host-write and response-pop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (wr_fire && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (rsp_pop && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dpram_port_master.sv
// tb/tb_dpram_port_master.sv - randomized model-checked bench for dpram_port_master
module tb_dpram_port_master;

    localparam int W = 8;
    localparam int A = 8;
    localparam int D = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_req_valid, wr_req_ready;
    logic [A-1:0] wr_req_addr;
    logic [W-1:0] wr_req_data;
    logic         rd_req_valid, rd_req_ready;
    logic [A-1:0] rd_req_addr;
    logic         rd_rsp_valid, rd_rsp_ready;
    logic [W-1:0] rd_rsp_data;
    logic         fill_start, fill_busy, fill_done;
    logic [W-1:0] fill_value;
    logic         ram_wr_en, ram_rd_en;
    logic [A-1:0] ram_wr_addr, ram_rd_addr;
    logic [W-1:0] ram_data_in, ram_data_out;
`ifdef ACCESS_CNT_EN
    logic [15:0]  wr_count, rd_count;
`endif

    always #5 clk = ~clk;

    dpram_port_master dut (
        .clk(clk), .rst(rst),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
        .fill_start(fill_start), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
`ifdef ACCESS_CNT_EN
        .wr_count(wr_count), .rd_count(rd_count),
`endif
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
    );

    // Asynchronous dual-port RAM with write-to-read forwarding; floats when not read
    logic [W-1:0] ram_mem [D];
    assign ram_data_out = !ram_rd_en ? {W{1'bx}} :
                          (ram_wr_en && (ram_wr_addr == ram_rd_addr)) ? ram_data_in :
                          ram_mem[ram_rd_addr];

    int tests = 0;
    int fails = 0;

    // Reference model: what each cycle's outputs must be
    logic [W-1:0] gmem [D];
    logic [W-1:0] m_rspq [$];
    bit           m_busy, m_done, m_wen, m_ren;
    int           m_fidx, m_wcnt, m_rcnt;
    logic [W-1:0] m_fval, m_wdata;
    logic [A-1:0] m_waddr, m_raddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_and_step();
        bit pop, exp_wrdy, exp_rrdy;
        pop      = (m_rspq.size() > 0) && rd_rsp_ready;
        exp_wrdy = !rst && !m_busy && !fill_start;
        exp_rrdy = exp_wrdy && ((m_rspq.size() + int'(m_ren) - int'(pop)) < 2);
        chk("wr_req_ready", 32'(wr_req_ready), 32'(exp_wrdy));
        chk("rd_req_ready", 32'(rd_req_ready), 32'(exp_rrdy));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(m_wen));
        if (m_wen) chk("ram_wr_addr_data", 32'({ram_wr_addr, ram_data_in}), 32'({m_waddr, m_wdata}));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(m_ren));
        if (m_ren) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_raddr));
        chk("rd_rsp_valid", 32'(rd_rsp_valid), 32'(m_rspq.size() > 0));
        if (m_rspq.size() > 0) chk("rd_rsp_data", 32'(rd_rsp_data), 32'(m_rspq[0]));
        chk("fill_busy", 32'(fill_busy), 32'(m_busy));
        chk("fill_done", 32'(fill_done), 32'(m_done));
`ifdef ACCESS_CNT_EN
        chk("wr_count", 32'(wr_count), 32'(m_wcnt));
        chk("rd_count", 32'(rd_count), 32'(m_rcnt));
`endif
        // RAM array takes the DUT's strobe; the golden copy takes the model's
        if (ram_wr_en) ram_mem[ram_wr_addr] = ram_data_in;
        if (m_wen) gmem[m_waddr] = m_wdata;
        if (rst) begin
            m_rspq.delete();
            m_busy = 0; m_done = 0; m_wen = 0; m_ren = 0;
            m_fidx = 0; m_wcnt = 0; m_rcnt = 0;
            return;
        end
        if (pop) begin
            void'(m_rspq.pop_front());
            m_rcnt++;
        end
        if (m_ren) m_rspq.push_back(gmem[m_raddr]);
        m_done = 0;
        if (m_busy) begin
            if (m_fidx == D) begin
                m_busy = 0; m_done = 1; m_wen = 0;
            end else begin
                m_wen = 1; m_waddr = A'(m_fidx); m_wdata = m_fval; m_fidx++;
            end
        end else if (fill_start) begin
            m_busy = 1; m_fval = fill_value; m_fidx = 1;
            m_wen = 1; m_waddr = '0; m_wdata = fill_value;
        end else begin
            m_wen = wr_req_valid;
            if (wr_req_valid) begin
                m_waddr = wr_req_addr; m_wdata = wr_req_data; m_wcnt++;
            end
        end
        m_ren = rd_req_valid && exp_rrdy;
        if (m_ren) m_raddr = rd_req_addr;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req_valid = 0; rd_req_valid = 0; fill_start = 0;
        wr_req_addr = A'($urandom); wr_req_data = W'($urandom);
        rd_req_addr = A'($urandom); fill_value = W'($urandom);
    endtask

    task automatic read_expect(input string name, input logic [A-1:0] addr, input logic [W-1:0] exp);
        rd_rsp_ready = 1; rd_req_valid = 1; rd_req_addr = addr;
        for (int i = 0; i < 10 && !rd_req_ready; i++) cycle();
        cycle();
        idle_inputs();
        cycle();
        chk(name, 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, exp}));
    endtask

    initial begin
        int acc, nwr, last_wr, done_seen, seq_err, iter, found;
        for (int i = 0; i < D; i++) begin
            ram_mem[i] = '0;
            gmem[i]    = '0;
        end
        rst = 1; rd_rsp_ready = 1;
        idle_inputs();

        // Reset
        repeat (3) cycle();
        chk("reset_ctrl", 32'({wr_req_ready, rd_req_ready, rd_rsp_valid, fill_busy,
                                fill_done, ram_wr_en, ram_rd_en}), 32'h0);
        chk("reset_bus", {ram_wr_addr, ram_data_in, ram_rd_addr, rd_rsp_data}, 32'h0);
        rst = 0;
        #1 chk("ready_after_reset", 32'({wr_req_ready, rd_req_ready}), 32'h3);

        // Write then read
        wr_req_valid = 1; wr_req_addr = 8'h10; wr_req_data = 8'hA5;
        cycle();
        chk("t2_wr_strobe", 32'({ram_wr_en, ram_wr_addr, ram_data_in}), 32'({1'b1, 8'h10, 8'hA5}));
        idle_inputs(); rd_req_valid = 1; rd_req_addr = 8'h10;
        cycle();
        chk("t2_strobes", 32'({ram_wr_en, ram_rd_en, ram_rd_addr}), 32'({1'b0, 1'b1, 8'h10}));
        idle_inputs();
        cycle();
        chk("t2_rsp", 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, 8'hA5}));

        // Same-cycle write and read to one address
        idle_inputs();
        wr_req_valid = 1; wr_req_addr = 8'h20; wr_req_data = 8'h3C;
        rd_req_valid = 1; rd_req_addr = 8'h20;
        cycle();
        chk("t3_strobes", 32'({ram_wr_en, ram_rd_en}), 32'h3);
        idle_inputs();
        cycle();
        chk("t3_rsp", 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, 8'h3C}));

        // Backpressure: only two reads fit
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            wr_req_valid = 1; wr_req_addr = A'(8'h30 + i); wr_req_data = W'(8'h11 * (i + 1));
            cycle();
        end
        idle_inputs(); cycle();
        rd_rsp_ready = 0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            rd_req_valid = 1; rd_req_addr = A'(8'h30 + i);
            if (rd_req_ready) acc++;
            cycle();
        end
        idle_inputs();
        chk("t4_accepted", acc, 2);
        chk("t4_ready_low", 32'(rd_req_ready), 0);
        repeat (2) cycle();
        chk("t4_head_held", 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, 8'h11}));
        rd_rsp_ready = 1;
        cycle();
        chk("t4_second", 32'({rd_rsp_valid, rd_rsp_data}), 32'({1'b1, 8'h22}));
        cycle();
        chk("t4_drained", 32'({rd_rsp_valid, rd_req_ready}), 32'h1);

        // Full fill with 8'hFF
        fill_value = 8'hFF; fill_start = 1;
        cycle();
        idle_inputs();
        nwr = 0; last_wr = -10; done_seen = 0; seq_err = 0; iter = 0;
        for (int i = 0; i < 300 && done_seen == 0; i++) begin
            if (ram_wr_en) begin
                if (ram_wr_addr != A'(nwr) || ram_data_in != 8'hFF) seq_err++;
                nwr++; last_wr = i;
            end
            if (fill_busy && (wr_req_ready || rd_req_ready)) seq_err++;
            if (fill_done) begin
                done_seen = 1; iter = i;
            end else begin
                wr_req_valid = 1'($urandom); rd_req_valid = 1'($urandom);
                wr_req_addr = A'($urandom); rd_req_addr = A'($urandom);
                cycle();
            end
        end
        idle_inputs();
        chk("t5_fill_writes", nwr, 256);
        chk("t5_done_seen", done_seen, 1);
        chk("t5_done_gap", iter - last_wr, 1);
        chk("t5_seq_err", seq_err, 0);
        repeat (3) cycle();
        read_expect("t5_read_7f", 8'h7F, 8'hFF);

        // Reset in the middle of a fill
        fill_value = 8'h5A; fill_start = 1;
        cycle();
        idle_inputs();
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (ram_wr_en && ram_wr_addr == 8'd100) begin
                found = 1;
                break;
            end
            cycle();
        end
        chk("t6_reached_100", found, 1);
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_busy_cleared", 32'(fill_busy), 0);
        nwr = 0; done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (ram_wr_en) nwr++;
            if (fill_done) done_seen++;
            cycle();
        end
        chk("t6_no_writes", nwr, 0);
        chk("t6_no_done", done_seen, 0);
        read_expect("t6_read_50", 8'd50, 8'h5A);
        read_expect("t6_read_100", 8'd100, 8'h5A);
        read_expect("t6_read_101", 8'd101, 8'hFF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            wr_req_valid = 1'($urandom); wr_req_addr = A'($urandom_range(0, 15));
            wr_req_data = W'($urandom);
            rd_req_valid = 1'($urandom); rd_req_addr = A'($urandom_range(0, 15));
            rd_rsp_ready = ($urandom_range(0, 3) != 0);
            fill_start = ($urandom_range(0, 499) == 0);
            fill_value = W'($urandom);
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 0; rd_rsp_ready = 1;
        idle_inputs();
        repeat (300) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dpram_port_master.md
Name: dpram_port_master

Overview:
- Synchronous initiator that drives both ports of the team's asynchronous dual-port RAM.
- Converts valid/ready write and read request streams into single-cycle RAM strobes.
- Captures read data into a 2-entry response buffer with backpressure.
- Includes a fill engine that sweeps every address with a constant value. This is the controlled alternative to the RAM's combinational clear.

Parameters:
- RAM_WIDTH, 8, data width
- ADDR_SIZE, 8, address width
- RAM_DEPTH, 256, number of words; must equal 2**ADDR_SIZE
- RSP_DEPTH, 2, read response buffer entries (fixed at 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted when high with valid
- wr_req_addr  in  ADDR_SIZE  write address
- wr_req_data  in  RAM_WIDTH  write data
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted when high with valid
- rd_req_addr  in  ADDR_SIZE  read address
- rd_rsp_valid  out  1  read response valid
- rd_rsp_ready  in  1  read response consumed when high with valid
- rd_rsp_data  out  RAM_WIDTH  read response data
- fill_start  in  1  single-cycle pulse that starts a fill
- fill_value  in  RAM_WIDTH  fill data, sampled on the fill_start cycle
- fill_busy  out  1  high while fill is active
- fill_done  out  1  one-cycle pulse after the last fill write
- ram_wr_en  out  1  to RAM wr_en
- ram_wr_addr  out  ADDR_SIZE  to RAM wr_addr
- ram_data_in  out  RAM_WIDTH  to RAM data_in
- ram_rd_en  out  1  to RAM rd_en
- ram_rd_addr  out  ADDR_SIZE  to RAM rd_addr
- ram_data_out  in  RAM_WIDTH  from RAM data_out

Behaviour:
- Reset values:
  - All outputs are 0, ram_* included.
  - Response buffer is empty, in-flight count is 0, FSM is IDLE.
  - rst mid-fill aborts the fill with no fill_done; writes already performed remain in the RAM.
- FSM states: IDLE and FILL.
  - IDLE -> FILL on fill_start. fill_start is ignored while FILL.
  - FILL -> IDLE after address RAM_DEPTH-1 is written; fill_done pulses on the following cycle.
- Write path:
  - wr_req_ready = (state==IDLE) && !fill_start.
  - A request accepted in cycle N gives ram_wr_en=1 in cycle N+1 only, with registered addr/data.
  - ram_wr_en is 0 in every cycle without a new write.
- Read path:
  - A request accepted in cycle N gives ram_rd_en=1 and ram_rd_addr in cycle N+1.
  - ram_data_out is sampled at the end of N+1 into the response buffer.
  - rd_rsp_valid rises in N+2. Latency is 2 cycles.
  - ram_rd_en is 0 when no read is in flight, so the RAM drives Z, which is never sampled.
- Reads during fill: rd_req_ready=0 while FILL and on the fill_start cycle. In-flight reads complete normally.
- Credit rule:
  - rd_req_ready requires (buffered entries + in-flight reads) < 2, evaluated so that a same-cycle pop frees a slot.
  - Responses are never dropped or overwritten.
- Response buffer:
  - FIFO order.
  - Simultaneous push and pop at full is legal.
  - rd_rsp_data stays stable while rd_rsp_valid && !rd_rsp_ready.
- Simultaneous write and read to the same address accepted in the same cycle:
  - Both strobes are issued in the same RAM cycle.
  - The RAM forwards, so the response carries the new write data.
- Write then read to the same address in consecutive cycles: the response carries the new data.
- Fill:
  - One write per cycle: ram_wr_addr = 0,1,...,RAM_DEPTH-1, ram_data_in = fill_value.
  - Exactly RAM_DEPTH cycles of ram_wr_en.
  - The address counter is ADDR_SIZE+1 bits wide to detect the terminal count without wrap ambiguity.
- Request inputs are X-tolerant when their valid is low.

Optional Feature:
- Macro ACCESS_CNT_EN.
- When defined, adds outputs wr_count[15:0] and rd_count[15:0].
  - wr_count counts host writes issued; fill writes are excluded.
  - rd_count counts responses popped.
  - Both saturate at 16'hFFFF and clear on rst.
- When not defined, the ports are absent and no counter logic exists.

Decomposition:
- Package dpram_pkg holds:
  - the state enum (IDLE, FILL)
  - the default width constants RAM_WIDTH_DEF=8 and ADDR_SIZE_DEF=8
  - RSP_DEPTH=2
- Sub-module dpram_rsp_fifo: 2-entry synchronous FIFO with push, pop, full, empty and data.
  - The top owns credit accounting and the FSM.

Test Plan:
1. Reset: assert rst 3 cycles -> all outputs 0, fill_busy=0, rd_rsp_valid=0.
2. Write addr 8'h10 data 8'hA5, then read 8'h10 -> ram_wr_en one cycle at N+1; rd_rsp_data=8'hA5 with rd_rsp_valid at read-accept+2.
3. Same-cycle write 8'h20/8'h3C and read 8'h20 -> response 8'h3C.
4. Hold rd_rsp_ready=0 and issue 4 reads -> exactly 2 accepted, rd_req_ready=0 afterward, data held stable; release -> 2 responses in order, ready reasserts.
5. fill_start with fill_value 8'hFF -> 256 consecutive ram_wr_en cycles with addresses 0..255, fill_done one cycle later, wr/rd_req_ready=0 throughout; then read 8'h7F -> 8'hFF.
6. rst asserted at fill address 100 -> fill_busy=0 next cycle, no fill_done, no further ram_wr_en.
